// File: rtl/fixed_point_accumulator.sv
// Streaming signed accumulator fed by an N-bit adder (a=acc, b=in_data, ci=0).
// Sums one packet of two's-complement beats with optional saturation and
// presents total, beat count and sticky overflow on an output handshake.
//
// state | meaning
// IDLE  | waiting for the first beat of a packet
// ACC   | packet open, adding beats into acc
// HOLD  | result presented, waiting for out_ready
module fixed_point_accumulator #(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [N-1:0]     MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]     MIN_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic [N-1:0]     acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             ovf, ovf_next;
    logic             sat_q, sat_next;

    logic [N-1:0]     sum;
    logic             add_ovf;
    logic [N-1:0]     add_result;
    logic             beat;

    // Adder with carry-in tied low; overflow when like-signed operands
    // produce a result of the opposite sign.
    assign sum        = acc + in_data;
    assign add_ovf    = (acc[N-1] == in_data[N-1]) && (sum[N-1] != acc[N-1]);
    // Clamp direction follows the sign of acc, which equals the operand sign
    // whenever overflow is possible.
    assign add_result = (add_ovf && sat_q) ? (acc[N-1] ? MIN_NEG : MAX_POS) : sum;

    // rst gates the handshakes combinationally so nothing is offered or
    // accepted during a reset cycle, whatever state was left behind.
    assign in_ready     = (state != HOLD) && !rst;
    assign out_valid    = (state == HOLD) && !rst;
    assign beat         = in_valid && in_ready;

    assign out_data     = acc;
    assign out_overflow = ovf;
    assign out_count    = cnt;

    // Next-state and datapath update for each accepted beat / result drain.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        sat_next   = sat_q;
        case (state)
            IDLE: begin
                if (beat) begin
                    acc_next   = in_data;
                    cnt_next   = CNT_ONE;
                    ovf_next   = 1'b0;
                    sat_next   = sat_en;
                    state_next = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_next   = add_result;
                    cnt_next   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    ovf_next   = ovf | add_ovf;
                    state_next = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and accumulator registers; reset discards any partial or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
            sat_q <= sat_next;
        end
    end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Bench for fixed_point_accumulator: one N=32/CNT_W=8 instance and one
// N=8/CNT_W=2 instance share the same stimulus. An arithmetic reference model
// is compared every cycle, and directed packets carry literal expectations.
module tb_fixed_point_accumulator;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, sat_en, out_ready;
    logic [31:0] in_data;
    logic [7:0]  d8;
    assign d8 = in_data[7:0];

    logic        rdy32, v32, ovf32;
    logic [31:0] o32;
    logic [7:0]  c32;
    logic        rdy8, v8, ovf8;
    logic [7:0]  o8;
    logic [1:0]  c8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fixed_point_accumulator #(.N(32), .CNT_W(8)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_data(in_data), .in_last(in_last), .sat_en(sat_en),
        .out_valid(v32), .out_ready(out_ready), .out_data(o32),
        .out_overflow(ovf32), .out_count(c32)
    );

    fixed_point_accumulator #(.N(8), .CNT_W(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .in_data(d8), .in_last(in_last), .sat_en(sat_en),
        .out_valid(v8), .out_ready(out_ready), .out_data(o8),
        .out_overflow(ovf8), .out_count(c8)
    );

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------
    // phase: 0 = no packet open, 1 = packet open, 2 = result waiting
    int     phase = 0;
    bit     started = 1'b0;
    longint macc[2];
    int     mcnt[2];
    bit     movf[2];
    bit     msat;
    int     wid[2] = '{32, 8};
    int     cmax[2] = '{255, 3};
    longint xin[2];
    longint s, lim_hi, lim_lo, m;
    bit     take;

    always @(posedge clk) begin
        if (rst) begin
            phase   = 0;
            started = 1'b1;
            for (int i = 0; i < 2; i++) begin
                macc[i] = 0;
                mcnt[i] = 0;
                movf[i] = 1'b0;
            end
        end else begin
            take   = in_valid && (phase != 2);
            xin[0] = longint'($signed(in_data));
            xin[1] = longint'($signed(d8));
            if (phase == 2 && out_ready) phase = 0;
            if (take) begin
                if (phase == 0) msat = sat_en;
                for (int i = 0; i < 2; i++) begin
                    if (phase == 0) begin
                        macc[i] = xin[i];
                        mcnt[i] = 1;
                        movf[i] = 1'b0;
                    end else begin
                        lim_hi = (longint'(1) <<< (wid[i] - 1)) - 1;
                        lim_lo = -(longint'(1) <<< (wid[i] - 1));
                        m      = longint'(1) <<< wid[i];
                        s      = macc[i] + xin[i];
                        if (s > lim_hi || s < lim_lo) begin
                            movf[i] = 1'b1;
                            if (msat) s = (s > lim_hi) ? lim_hi : lim_lo;
                            else if (s > lim_hi) s = s - m;
                            else s = s + m;
                        end
                        macc[i] = s;
                        if (mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
                    end
                end
                phase = in_last ? 2 : 1;
            end
        end
    end

    // Every-cycle comparison of handshakes and, while a result is offered, its contents.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready32", rdy32, (!rst && phase != 2));
            chk("in_ready8", rdy8, (!rst && phase != 2));
            chk("out_valid32", v32, (!rst && phase == 2));
            chk("out_valid8", v8, (!rst && phase == 2));
            if (!rst && phase == 2) begin
                chk("model_data32", $signed(o32), macc[0]);
                chk("model_cnt32", c32, mcnt[0]);
                chk("model_ovf32", ovf32, movf[0]);
                chk("model_data8", $signed(o8), macc[1]);
                chk("model_cnt8", c8, mcnt[1]);
                chk("model_ovf8", ovf8, movf[1]);
            end
        end
    end

    // ---------------- directed stimulus ------------------------------------
    task automatic beat(input logic [31:0] d, input logic last, input logic s_en);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        sat_en   = s_en;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last beat with out_ready=1: the result must be
    // present this cycle and drained by the next edge.
    task automatic result(input string tag, input longint e32, input int n32,
                          input bit f32, input longint e8, input int n8, input bit f8);
        @(negedge clk);
        chk({tag, "_valid32"}, v32, 1);
        chk({tag, "_data32"}, $signed(o32), e32);
        chk({tag, "_cnt32"}, c32, n32);
        chk({tag, "_ovf32"}, ovf32, f32);
        chk({tag, "_valid8"}, v8, 1);
        chk({tag, "_data8"}, $signed(o8), e8);
        chk({tag, "_cnt8"}, c8, n8);
        chk({tag, "_ovf8"}, ovf8, f8);
        chk({tag, "_model8"}, macc[1], e8);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        sat_en    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", v32, 0);
        chk("rst_data32", o32, 0);
        chk("rst_data8", o8, 0);
        chk("rst_cnt32", c32, 0);
        chk("rst_ovf8", ovf8, 0);
        chk("rst_ready", rdy8, 1);
        @(posedge clk);
        #1;

        // basic wrapping sum
        beat(32'd5, 1'b0, 1'b0);
        beat(-32'sd3, 1'b0, 1'b0);
        beat(32'd10, 1'b1, 1'b0);
        result("sum3", 12, 3, 0, 12, 3, 0);

        // saturating: 8-bit clamps to 127 then subtracts 50
        beat(32'd100, 1'b0, 1'b1);
        beat(32'd100, 1'b0, 1'b1);
        beat(-32'sd50, 1'b1, 1'b1);
        result("satpos", 150, 3, 0, 77, 3, 1);

        // wrapping positive and negative overflow
        beat(32'd100, 1'b0, 1'b0);
        beat(32'd100, 1'b1, 1'b0);
        result("wrappos", 200, 2, 0, -56, 2, 1);
        beat(-32'sd100, 1'b0, 1'b0);
        beat(-32'sd100, 1'b1, 1'b0);
        result("wrapneg", -200, 2, 0, 56, 2, 1);

        // sat_en raised on a later beat must not take effect
        beat(32'd100, 1'b0, 1'b0);
        beat(32'd100, 1'b1, 1'b1);
        result("satmid", 200, 2, 0, -56, 2, 1);

        // negative clamp, then the clamped value keeps accumulating
        beat(-32'sd100, 1'b0, 1'b1);
        beat(-32'sd100, 1'b0, 1'b1);
        beat(32'd1, 1'b1, 1'b1);
        result("satneg", -199, 3, 0, -127, 3, 1);

        // back-pressure: result held, junk beat offered during HOLD is ignored
        out_ready = 1'b0;
        beat(32'd3, 1'b0, 1'b0);
        beat(32'd4, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", v32, 1);
            chk("bp_data32", o32, 7);
            chk("bp_data8", o8, 7);
            chk("bp_ready", rdy32, 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        beat(32'd1, 1'b0, 1'b0);
        beat(32'd2, 1'b1, 1'b0);
        result("afterbp", 3, 2, 0, 3, 2, 0);

        // reset in the middle of a packet discards it
        beat(32'd1, 1'b0, 1'b0);
        beat(32'd2, 1'b0, 1'b0);
        beat(32'd3, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(32'd7, 1'b1, 1'b0);
        result("midrst", 7, 1, 0, 7, 1, 0);

        // beat counter saturation on the 2-bit counter, sat_en toggling
        beat(32'd1, 1'b0, 1'b0);
        beat(32'd1, 1'b0, 1'b1);
        beat(32'd1, 1'b0, 1'b0);
        beat(32'd1, 1'b0, 1'b1);
        beat(32'd1, 1'b1, 1'b0);
        result("cntsat", 5, 5, 0, 5, 3, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
